// File: rtl/vga_fetch_pkg.sv
// Shared types and constants for the VGA scan-out fetch scheduler.
// FSM state encoding and the per-word address step.
package vga_fetch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE = 3'd0;
  localparam state_t FILL = 3'd1;
  localparam state_t READ = 3'd2;
  localparam state_t PUSH = 3'd3;
  localparam state_t DONE = 3'd4;

  localparam int ADDR_STEP = 2;

endpackage

// File: rtl/vga_fetch_addr_gen.sv
// Frame address and word counter for the fetch scheduler.
// Loads on restart, steps one 16-bit word per push, flags the last word.
module vga_fetch_addr_gen
  import vga_fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              inc,
  input  logic [15:0]       frame_words,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [15:0]       cnt_d, cnt_q;

  // Load wins over increment; address wraps naturally.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load) begin
      addr_d = load_base;
      cnt_d  = 16'd0;
    end else if (inc) begin
      addr_d = addr_q + STEP;
      cnt_d  = cnt_q + 16'd1;
    end
  end

  // Address and count registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q + 16'd1) == frame_words;

endmodule

// File: rtl/vga_fetch_sched.sv
// VGA frame fetch scheduler: Avalon-MM reads into a line FIFO.
// Optional double-buffer swap under VGA_FETCH_SWAP_EN.
module vga_fetch_sched
  import vga_fetch_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int USEDW_W    = 12,
  parameter int HIGH_WATER = 4000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  frame_base,
  input  logic [15:0]        frame_words,
  input  logic               vsync_pulse,
  input  logic               clr_underrun,
  output logic [ADDR_W-1:0]  avm_read_address,
  output logic               avm_read_read,
  input  logic [15:0]        avm_read_readdata,
  input  logic               avm_read_waitrequest,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  output logic               fifo_write,
  output logic [15:0]        fifo_writedata,
`ifdef VGA_FETCH_SWAP_EN
  input  logic [ADDR_W-1:0]  back_base,
  input  logic               swap_req,
  output logic               swap_done,
`endif
  output logic               busy,
  output logic               underrun
);

  localparam logic [USEDW_W-1:0] HW = USEDW_W'(HIGH_WATER);

  state_t      state_d, state_q;
  logic [15:0] data_d, data_q;
  logic        pend_d, pend_q;
  logic        ur_d, ur_q;
  logic        restart;
  logic        inc;
  logic        cap;
  logic        set_ur;
  logic        last;
  logic        has_words;
  logic [ADDR_W-1:0] base_sel;

  assign has_words = frame_words != 16'd0;

  // Next-state logic; restart relatches base and clears the count.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    restart = 1'b0;
    inc     = 1'b0;
    cap     = 1'b0;
    set_ur  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vsync_pulse && enable && has_words) begin
          restart = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        set_ur = vsync_pulse;
        if (!enable) begin
          state_d = IDLE;
        end else if (vsync_pulse) begin
          restart = 1'b1;
        end else if (fifo_wrusedw < HW) begin
          state_d = READ;
        end
      end
      READ: begin
        set_ur = vsync_pulse;
        if (vsync_pulse) pend_d = 1'b1;
        if (!avm_read_waitrequest) begin
          if (pend_q || vsync_pulse) begin
            restart = 1'b1;
            pend_d  = 1'b0;
            state_d = FILL;
          end else begin
            cap     = 1'b1;
            state_d = PUSH;
          end
        end
      end
      PUSH: begin
        set_ur = vsync_pulse;
        if (!enable) begin
          inc     = 1'b1;
          state_d = IDLE;
        end else if (vsync_pulse) begin
          restart = 1'b1;
          state_d = FILL;
        end else begin
          inc     = 1'b1;
          state_d = last ? DONE : FILL;
        end
      end
      DONE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (vsync_pulse && has_words) begin
          restart = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data capture and sticky underrun; set wins over clear.
  always_comb begin
    data_d = cap ? avm_read_readdata : data_q;
    ur_d   = (ur_q & ~clr_underrun) | set_ur;
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      pend_q  <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      ur_q    <= ur_d;
    end
  end

`ifdef VGA_FETCH_SWAP_EN
  logic swap_pend_d, swap_pend_q;
  logic swap_done_d, swap_done_q;

  // Pending swap is consumed by the next restart; a new request wins.
  always_comb begin
    swap_pend_d = swap_pend_q;
    if (restart) swap_pend_d = 1'b0;
    if (swap_req) swap_pend_d = 1'b1;
    swap_done_d = restart & swap_pend_q;
    base_sel    = swap_pend_q ? back_base : frame_base;
  end

  // Swap bookkeeping registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_pend_q <= swap_pend_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign swap_done = swap_done_q;
`else
  assign base_sel = frame_base;
`endif

  vga_fetch_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (restart),
    .load_base  (base_sel),
    .inc        (inc),
    .frame_words(frame_words),
    .addr       (avm_read_address),
    .last       (last)
  );

  assign avm_read_read  = state_q == READ;
  assign fifo_write     = state_q == PUSH;
  assign fifo_writedata = data_q;
  assign busy           = (state_q == FILL) ||
                          (state_q == READ) ||
                          (state_q == PUSH);
  assign underrun       = ur_q;

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Directed self-checking bench for vga_fetch_sched.
// Define VGA_FETCH_SWAP_EN to also exercise the swap path.
module tb_vga_fetch_sched;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] frame_base;
  logic [15:0] frame_words;
  logic        vsync_pulse;
  logic        clr_underrun;
  logic [31:0] avm_read_address;
  logic        avm_read_read;
  logic [15:0] avm_read_readdata;
  logic        avm_read_waitrequest;
  logic [11:0] fifo_wrusedw;
  logic        fifo_write;
  logic [15:0] fifo_writedata;
  logic        busy;
  logic        underrun;
`ifdef VGA_FETCH_SWAP_EN
  logic [31:0] back_base;
  logic        swap_req;
  logic        swap_done;
`endif

  int checks = 0;
  int failures = 0;

  vga_fetch_sched #(
    .ADDR_W    (32),
    .USEDW_W   (12),
    .HIGH_WATER(4000)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .enable              (enable),
    .frame_base          (frame_base),
    .frame_words         (frame_words),
    .vsync_pulse         (vsync_pulse),
    .clr_underrun        (clr_underrun),
    .avm_read_address    (avm_read_address),
    .avm_read_read       (avm_read_read),
    .avm_read_readdata   (avm_read_readdata),
    .avm_read_waitrequest(avm_read_waitrequest),
    .fifo_wrusedw        (fifo_wrusedw),
    .fifo_write          (fifo_write),
    .fifo_writedata      (fifo_writedata),
`ifdef VGA_FETCH_SWAP_EN
    .back_base           (back_base),
    .swap_req            (swap_req),
    .swap_done           (swap_done),
`endif
    .busy                (busy),
    .underrun            (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic vsync();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
  endtask

  task automatic finish_frame(input int exp_pushes, input string nm);
    int pushes = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      if (fifo_write) pushes++;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || pushes != exp_pushes) begin
      failures++;
      $display("FAIL %s: busy=%0b pushes=%0d, expected busy=0 pushes=%0d",
               nm, busy, pushes, exp_pushes);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    frame_base = 32'h0;
    frame_words = 16'd0;
    vsync_pulse = 1'b0;
    clr_underrun = 1'b0;
    avm_read_readdata = 16'h0;
    avm_read_waitrequest = 1'b0;
    fifo_wrusedw = 12'd0;
`ifdef VGA_FETCH_SWAP_EN
    back_base = 32'h0;
    swap_req = 1'b0;
`endif
    tick();
    tick();
    checks++;
    if ({avm_read_read, fifo_write, busy, underrun} !== 4'b0000 ||
        avm_read_address !== 32'h0 || fifo_writedata !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: rd=%0b wr=%0b busy=%0b ur=%0b a=%h d=%h, expected all 0",
               avm_read_read, fifo_write, busy, underrun,
               avm_read_address, fifo_writedata);
    end
    reset_n = 1'b1;
    tick();
    enable = 1'b1;
    vsync();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_words_idle: busy=%0b, expected 0", busy);
    end
    enable = 1'b0;
    frame_words = 16'd4;
    vsync();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL disabled_idle: busy=%0b, expected 0", busy);
    end
  endtask

  task automatic test_basic_frame();
    enable = 1'b1;
    frame_base = 32'h1000;
    frame_words = 16'd4;
    vsync();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({busy, avm_read_read, fifo_write} !== 3'b100) begin
        failures++;
        $display("FAIL basic_fill[%0d]: bsy/rd/wr=%b, expected 100",
                 i, {busy, avm_read_read, fifo_write});
      end
      tick();
      checks++;
      if (avm_read_read !== 1'b1 ||
          avm_read_address !== 32'h1000 + 32'(2 * i)) begin
        failures++;
        $display("FAIL basic_read[%0d]: rd=%0b a=%h, expected rd=1 a=%h",
                 i, avm_read_read, avm_read_address, 32'h1000 + 32'(2 * i));
      end
      avm_read_readdata = 16'hC000 + 16'(i);
      tick();
      checks++;
      if ({avm_read_read, fifo_write} !== 2'b01 ||
          fifo_writedata !== 16'hC000 + 16'(i)) begin
        failures++;
        $display("FAIL basic_push[%0d]: rd/wr=%b d=%h, expected 01 d=%h",
                 i, {avm_read_read, fifo_write}, fifo_writedata,
                 16'hC000 + 16'(i));
      end
      tick();
    end
    checks++;
    if ({busy, avm_read_read, fifo_write} !== 3'b000) begin
      failures++;
      $display("FAIL basic_done: bsy/rd/wr=%b, expected 000",
               {busy, avm_read_read, fifo_write});
    end
  endtask

  task automatic test_waitrequest();
    vsync();
    tick();
    tick();
    tick();
    avm_read_waitrequest = 1'b1;
    avm_read_readdata = 16'hBEEF;
    tick();
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (avm_read_read !== 1'b1 || avm_read_address !== 32'h1002 ||
          fifo_write !== 1'b0) begin
        failures++;
        $display("FAIL wait_hold[%0d]: rd=%0b wr=%0b a=%h, expected rd=1 wr=0 a=00001002",
                 k, avm_read_read, fifo_write, avm_read_address);
      end
      if (k == 5) avm_read_waitrequest = 1'b0;
      tick();
    end
    checks++;
    if ({avm_read_read, fifo_write} !== 2'b01 || fifo_writedata !== 16'hBEEF) begin
      failures++;
      $display("FAIL wait_push: rd/wr=%b d=%h, expected 01 d=beef",
               {avm_read_read, fifo_write}, fifo_writedata);
    end
    tick();
    checks++;
    if (fifo_write !== 1'b0) begin
      failures++;
      $display("FAIL wait_single_push: wr=%0b, expected 0", fifo_write);
    end
    finish_frame(2, "wait_tail");
  endtask

  task automatic test_high_water();
    fifo_wrusedw = 12'd4000;
    vsync();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({busy, avm_read_read} !== 2'b10) begin
        failures++;
        $display("FAIL hw_hold[%0d]: bsy/rd=%b, expected 10",
                 k, {busy, avm_read_read});
      end
      tick();
    end
    fifo_wrusedw = 12'd3999;
    tick();
    checks++;
    if (avm_read_read !== 1'b1 || avm_read_address !== 32'h1000) begin
      failures++;
      $display("FAIL hw_release: rd=%0b a=%h, expected rd=1 a=00001000",
               avm_read_read, avm_read_address);
    end
    fifo_wrusedw = 12'd0;
    finish_frame(4, "hw_tail");
  endtask

  task automatic test_underrun_read();
    vsync();
    tick();
    tick();
    tick();
    avm_read_waitrequest = 1'b1;
    tick();
    checks++;
    if (avm_read_read !== 1'b1 || avm_read_address !== 32'h1002) begin
      failures++;
      $display("FAIL ur_read_addr: rd=%0b a=%h, expected rd=1 a=00001002",
               avm_read_read, avm_read_address);
    end
    vsync();
    checks++;
    if (underrun !== 1'b1 || avm_read_read !== 1'b1) begin
      failures++;
      $display("FAIL ur_set: ur=%0b rd=%0b, expected ur=1 rd=1",
               underrun, avm_read_read);
    end
    avm_read_waitrequest = 1'b0;
    tick();
    checks++;
    if ({busy, avm_read_read, fifo_write} !== 3'b100) begin
      failures++;
      $display("FAIL ur_discard: bsy/rd/wr=%b, expected 100",
               {busy, avm_read_read, fifo_write});
    end
    tick();
    checks++;
    if (avm_read_read !== 1'b1 || avm_read_address !== 32'h1000 ||
        underrun !== 1'b1) begin
      failures++;
      $display("FAIL ur_restart: rd=%0b a=%h ur=%0b, expected rd=1 a=00001000 ur=1",
               avm_read_read, avm_read_address, underrun);
    end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL ur_clear: ur=%0b, expected 0", underrun);
    end
    finish_frame(4, "ur_tail");
  endtask

  task automatic test_sticky_fill();
    fifo_wrusedw = 12'd4000;
    vsync();
    tick();
    vsync_pulse = 1'b1;
    clr_underrun = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL set_beats_clear: ur=%0b bsy=%0b, expected ur=1 bsy=1",
               underrun, busy);
    end
    fifo_wrusedw = 12'd0;
    tick();
    checks++;
    if (avm_read_read !== 1'b1 || avm_read_address !== 32'h1000) begin
      failures++;
      $display("FAIL fill_restart: rd=%0b a=%h, expected rd=1 a=00001000",
               avm_read_read, avm_read_address);
    end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    finish_frame(4, "fill_tail");
    checks++;
    if (underrun !== 1'b0) begin
      failures++;
      $display("FAIL fill_clear: ur=%0b, expected 0", underrun);
    end
  endtask

`ifdef VGA_FETCH_SWAP_EN
  task automatic test_swap();
    back_base = 32'h8000;
    vsync();
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    finish_frame(4, "swap_frame");
    vsync();
    checks++;
    if (swap_done !== 1'b1) begin
      failures++;
      $display("FAIL swap_done_pulse: sd=%0b, expected 1", swap_done);
    end
    tick();
    checks++;
    if (avm_read_read !== 1'b1 || avm_read_address !== 32'h8000 ||
        swap_done !== 1'b0) begin
      failures++;
      $display("FAIL swap_addr: rd=%0b a=%h sd=%0b, expected rd=1 a=00008000 sd=0",
               avm_read_read, avm_read_address, swap_done);
    end
    finish_frame(4, "swap_tail");
  endtask
`endif

  task automatic test_reset_mid_read();
    vsync();
    avm_read_waitrequest = 1'b1;
    tick();
    checks++;
    if (avm_read_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_read: rd=%0b, expected 1", avm_read_read);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read_read, fifo_write, busy} !== 3'b000 ||
        avm_read_address !== 32'h0) begin
      failures++;
      $display("FAIL rst_async: rd/wr/bsy=%b a=%h, expected 000 a=0",
               {avm_read_read, fifo_write, busy}, avm_read_address);
    end
    tick();
    reset_n = 1'b1;
    avm_read_waitrequest = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || avm_read_read !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle: bsy=%0b rd=%0b, expected 0 0",
               busy, avm_read_read);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_waitrequest();
    test_high_water();
    test_underrun_read();
    test_sticky_fill();
`ifdef VGA_FETCH_SWAP_EN
    test_swap();
`endif
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
